modulus_peak_detect: RTL and testbench

- Downstream consumer of the modulus-calculation stage.
- Takes the stream of 31-bit magnitude samples (sample1) and splits it into frames of FRAME_LEN accepted samples.
- Per frame it reports the peak magnitude, the index of that peak, and the count of samples above a programmable threshold.
- The result is presented through a valid/ready output handshake to the software-facing register stage.

---
 rtl/modulus_peak_detect.sv | 120 ++++++++++++
 tb/tb_modulus_peak_detect.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/modulus_peak_detect.sv
// Per-frame peak magnitude, peak index and threshold hit count over a stream of
// magnitude samples, delivered through a valid/ready result register.
module modulus_peak_detect #(
  parameter int DATA_W    = 31,
  parameter int FRAME_LEN = 64,
  parameter int IDX_W     = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] sample1,
  input  logic [DATA_W-1:0] threshold,
  input  logic              frame_sync,
  output logic [DATA_W-1:0] peak_value,
  output logic [IDX_W-1:0]  peak_index,
  output logic [IDX_W:0]    hit_count,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overrun,
  output logic              fsm_state
);

  // Handshake: a result is transferred at a rising edge where ce && out_valid && out_ready;
  // while out_valid is high and no transfer occurs, the result outputs hold steady.

  typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

  localparam logic [IDX_W-1:0] LAST_K  = IDX_W'(FRAME_LEN - 1);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
  localparam logic [IDX_W:0]   HIT_ONE = (IDX_W + 1)'(1);

  state_t              state;
  state_t              state_next;
  logic [IDX_W-1:0]    cnt;
  logic [DATA_W-1:0]   max_r;
  logic [IDX_W-1:0]    idx_r;
  logic [IDX_W:0]      hits_r;

  logic                accept;
  logic [IDX_W-1:0]    k;
  logic                is_hit;
  logic [DATA_W-1:0]   max_n;
  logic [IDX_W-1:0]    idx_n;
  logic [IDX_W:0]      hits_n;
  logic                last;
  logic                consume;

  assign fsm_state = state;
  assign accept    = ce && in_valid;
  assign consume   = ce && out_valid && out_ready;

  // frame_sync makes the current sample position 0, so a simultaneous sample opens the new frame.
  always_comb begin
    k      = frame_sync ? '0 : cnt;
    is_hit = sample1 > threshold;
    max_n  = max_r;
    idx_n  = idx_r;
    hits_n = hits_r;
    if (k == '0) begin
      max_n  = sample1;
      idx_n  = '0;
      hits_n = is_hit ? HIT_ONE : '0;
    end else begin
      if (sample1 > max_r) begin
        max_n = sample1;
        idx_n = k;
      end
      if (is_hit) hits_n = hits_r + HIT_ONE;
    end
    last = accept && (k == LAST_K);
  end

  always_comb begin
    state_next = state;
    if (ce) begin
      if (accept)          state_next = last ? IDLE : ACCUM;
      else if (frame_sync) state_next = IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt        <= '0;
      max_r      <= '0;
      idx_r      <= '0;
      hits_r     <= '0;
      peak_value <= '0;
      peak_index <= '0;
      hit_count  <= '0;
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
    end else if (ce) begin
      if (accept) begin
        max_r  <= max_n;
        idx_r  <= idx_n;
        hits_r <= hits_n;
        cnt    <= last ? '0 : k + IDX_ONE;
      end else if (frame_sync) begin
        cnt <= '0;
      end
      if (last) begin
        peak_value <= max_n;
        peak_index <= idx_n;
        hit_count  <= hits_n;
        out_valid  <= 1'b1;
        // A result still waiting (not taken at this edge) is being replaced.
        if (out_valid && !out_ready) overrun <= 1'b1;
      end else if (consume) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_modulus_peak_detect.sv
// Scoreboard bench for modulus_peak_detect: frame-level reference model feeds an
// expected-result queue, a negedge monitor pops and compares on every transfer.
module tb_modulus_peak_detect;

  localparam int DW = 31;
  localparam int FL = 4;
  localparam int IW = 2;
  localparam int EW = DW + IW + (IW + 1) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          ce = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] sample1 = '0;
  logic [DW-1:0] threshold = '0;
  logic          frame_sync = 1'b0;
  logic [DW-1:0] peak_value;
  logic [IW-1:0] peak_index;
  logic [IW:0]   hit_count;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          overrun;
  logic          fsm_state;

  int compared = 0;
  int mismatched = 0;

  logic [EW-1:0] exp_q[$];
  int unsigned   fr_s[$];
  int unsigned   fr_t[$];
  bit            pending = 0;
  bit            ovr = 0;
  bit            cur_valid = 0;
  bit            cur_busy = 0;

  modulus_peak_detect #(.DATA_W(DW), .FRAME_LEN(FL), .IDX_W(IW)) dut (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .sample1(sample1),
    .threshold(threshold), .frame_sync(frame_sync), .peak_value(peak_value),
    .peak_index(peak_index), .hit_count(hit_count), .out_valid(out_valid),
    .out_ready(out_ready), .overrun(overrun), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Peak = first position holding the largest value; hits = samples strictly above their threshold.
  function automatic logic [EW-1:0] frame_result();
    int unsigned best = fr_s[0];
    int bi = 0;
    int h = 0;
    foreach (fr_s[i]) begin
      if (fr_s[i] > best) begin
        best = fr_s[i];
        bi = i;
      end
      if (fr_s[i] > fr_t[i]) h++;
    end
    return {DW'(best), IW'(bi), (IW + 1)'(h), ovr};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    fr_s.delete();
    fr_t.delete();
    pending = 0;
    ovr = 0;
    cur_valid = 0;
    cur_busy = 0;
  endtask

  // Predicts the effect of the coming rising edge from the inputs now on the pins.
  task automatic model_step();
    bit done = 0;
    cur_valid = pending;
    cur_busy = (fr_s.size() != 0);
    if (ce) begin
      if (frame_sync) begin
        fr_s.delete();
        fr_t.delete();
      end
      if (in_valid) begin
        fr_s.push_back(int'(sample1));
        fr_t.push_back(int'(threshold));
        if (fr_s.size() == FL) done = 1;
      end
    end
    if (done) begin
      if (pending && !out_ready) begin
        void'(exp_q.pop_back());
        ovr = 1;
      end
      exp_q.push_back(frame_result());
      fr_s.delete();
      fr_t.delete();
      pending = 1;
    end else if (pending && ce && out_ready) begin
      pending = 0;
    end
  endtask

  task automatic cyc(input bit c, input bit v, input int unsigned s, input int unsigned t,
                     input bit fs, input bit r);
    ce = c;
    in_valid = v;
    sample1 = DW'(s);
    threshold = DW'(t);
    frame_sync = fs;
    out_ready = r;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 1);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      check("out_valid", {63'd0, out_valid}, {63'd0, cur_valid});
      check("fsm_state", {63'd0, fsm_state}, {63'd0, cur_busy});
      if (ce && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL result: unexpected transfer got %0h expected none at %0t",
                   {peak_value, peak_index, hit_count, overrun}, $time);
        end else begin
          check("result", 64'({peak_value, peak_index, hit_count, overrun}), 64'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #12;
    check("rst_peak_value", 64'(peak_value), 0);
    check("rst_peak_index", 64'(peak_index), 0);
    check("rst_hit_count", 64'(hit_count), 0);
    check("rst_out_valid", 64'(out_valid), 0);
    check("rst_overrun", 64'(overrun), 0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Basic frame with threshold hits
    cyc(1, 1, 11, 20, 0, 1);
    cyc(1, 1, 22, 20, 0, 1);
    cyc(1, 1, 25, 20, 0, 1);
    cyc(1, 1, 50, 20, 0, 1);
    check("t1_valid", 64'(out_valid), 1);
    check("t1_peak", 64'(peak_value), 50);
    check("t1_index", 64'(peak_index), 3);
    check("t1_hits", 64'(hit_count), 3);
    idle(1);
    check("t1_drop", 64'(out_valid), 0);

    // Ties keep the earliest index
    cyc(1, 1, 40, 0, 0, 1);
    cyc(1, 1, 40, 0, 0, 1);
    cyc(1, 1, 7, 0, 0, 1);
    cyc(1, 1, 40, 0, 0, 1);
    check("t2_peak", 64'(peak_value), 40);
    check("t2_index", 64'(peak_index), 0);
    check("t2_hits", 64'(hit_count), 4);
    idle(1);

    // Overwrite of an unconsumed result
    cyc(1, 1, 5, 0, 0, 0);
    cyc(1, 1, 6, 0, 0, 0);
    cyc(1, 1, 7, 0, 0, 0);
    cyc(1, 1, 8, 0, 0, 0);
    cyc(1, 1, 9, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 0);
    check("t3_peak", 64'(peak_value), 9);
    check("t3_index", 64'(peak_index), 0);
    check("t3_overrun", 64'(overrun), 1);
    idle(2);
    check("t3_consumed", 64'(out_valid), 0);
    check("t3_sticky", 64'(overrun), 1);

    // frame_sync discards a partial frame
    cyc(1, 1, 30, 0, 0, 1);
    cyc(1, 1, 31, 0, 0, 1);
    cyc(1, 1, 2, 0, 1, 1);
    cyc(1, 1, 3, 0, 0, 1);
    cyc(1, 1, 4, 0, 0, 1);
    cyc(1, 1, 5, 0, 0, 1);
    check("t4_peak", 64'(peak_value), 5);
    check("t4_index", 64'(peak_index), 3);
    idle(1);

    // Gaps in in_valid and ce, including a sample offered while ce is low
    cyc(1, 1, 1, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 1);
    cyc(1, 1, 100, 0, 0, 1);
    cyc(0, 1, 999, 0, 1, 1);
    cyc(0, 1, 999, 0, 0, 1);
    cyc(1, 1, 2, 0, 0, 1);
    cyc(1, 1, 3, 0, 0, 1);
    check("t5_valid", 64'(out_valid), 1);
    check("t5_peak", 64'(peak_value), 100);
    check("t5_index", 64'(peak_index), 1);
    idle(1);

    // Asynchronous reset with a pending result and a partial frame
    cyc(1, 1, 1, 0, 0, 0);
    cyc(1, 1, 2, 0, 0, 0);
    cyc(1, 1, 3, 0, 0, 0);
    cyc(1, 1, 4, 0, 0, 0);
    cyc(1, 1, 7, 0, 0, 0);
    cyc(1, 1, 8, 0, 0, 0);
    #2;
    reset = 1'b0;
    #1;
    check("t6_peak", 64'(peak_value), 0);
    check("t6_index", 64'(peak_index), 0);
    check("t6_hits", 64'(hit_count), 0);
    check("t6_valid", 64'(out_valid), 0);
    check("t6_overrun", 64'(overrun), 0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    cyc(1, 1, 4, 3, 0, 1);
    cyc(1, 1, 9, 3, 0, 1);
    cyc(1, 1, 9, 3, 0, 1);
    cyc(1, 1, 1, 3, 0, 1);
    check("t6_new_peak", 64'(peak_value), 9);
    check("t6_new_index", 64'(peak_index), 1);
    check("t6_new_hits", 64'(hit_count), 3);
    idle(1);

    // Randomized traffic: small value range to force ties, occasional syncs and stalls
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7, $urandom_range(0, 15),
          $urandom_range(0, 15), $urandom_range(0, 29) == 0, $urandom_range(0, 9) < 7);
    end
    idle(6);
    check("drain", 64'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
